bus_xfer_ctrl: RTL and testbench

//  Parametrised, registered datapath bus with a transfer sequencer. It replaces the

---
 rtl/bus_xfer_ctrl.sv | 134 +++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - registered N-source datapath bus with handshake-driven transfer sequencer
// Accept samples the selected source once; DRIVE holds it, COMMIT strobes the destination.
module bus_xfer_ctrl #(
    parameter int DATA_W     = 16,
    parameter int NUM_SRC    = 10,
    parameter int SEL_W      = 4,
    parameter int NUM_DST    = 8,
    parameter int NARROW_IDX = 9,
    parameter int NARROW_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*DATA_W-1:0]   src_flat,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [SEL_W-1:0]            rd_sel,
    input  logic [SEL_W-1:0]            wr_sel,
    output logic [DATA_W-1:0]           bus_out,
    output logic [NUM_DST-1:0]          wr_en,
    output logic                        xfer_done,
    output logic                        err_sel,
    output logic [15:0]                 xfer_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] NARROW_MASK = DATA_W'({NARROW_W{1'b1}});

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   bus_q, bus_d;
    logic [SEL_W-1:0]    wr_sel_q, wr_sel_d;
    logic [NUM_DST-1:0]  wr_en_q, wr_en_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [15:0]         count_q, count_d;

    logic [DATA_W-1:0]   mux_val;
    logic [NUM_DST-1:0]  wr_onehot;
    logic                rd_illegal;
    logic                wr_illegal;

    // Codes 0 and above NUM_SRC fall through to zero, so an illegal read needs no extra gating.
    always_comb begin
        mux_val = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (rd_sel == SEL_W'(k)) begin
                if (k == NARROW_IDX) begin
                    mux_val = src_flat[(k-1)*DATA_W +: DATA_W] & NARROW_MASK;
                end else begin
                    mux_val = src_flat[(k-1)*DATA_W +: DATA_W];
                end
            end
        end
    end

    // An illegal captured wr_sel matches no bit, which suppresses the strobe.
    always_comb begin
        wr_onehot = '0;
        for (int d = 1; d <= NUM_DST; d++) begin
            if (wr_sel_q == SEL_W'(d)) begin
                wr_onehot[d-1] = 1'b1;
            end
        end
    end

    assign rd_illegal = (rd_sel > SEL_W'(NUM_SRC));
    assign wr_illegal = (wr_sel > SEL_W'(NUM_DST));

    always_comb begin
        state_d  = state_q;
        bus_d    = bus_q;
        wr_sel_d = wr_sel_q;
        wr_en_d  = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    bus_d    = mux_val;
                    wr_sel_d = wr_sel;
                    err_d    = rd_illegal | wr_illegal;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                wr_en_d = wr_onehot;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                done_d  = 1'b1;
                count_d = count_q + 16'd1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bus_q    <= '0;
            wr_sel_q <= '0;
            wr_en_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            bus_q    <= bus_d;
            wr_sel_q <= wr_sel_d;
            wr_en_q  <= wr_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    wire unused_ok = &{1'b0, state_q == S_COMMIT};

    assign xfer_count = count_q;
    assign req_ready  = (state_q == S_IDLE);
    assign bus_out    = bus_q;
    assign wr_en      = wr_en_q;
    assign xfer_done  = done_q;
    assign err_sel    = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - directed self-checking bench for bus_xfer_ctrl
module tb_bus_xfer_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [159:0] src_flat;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   rd_sel;
    logic [3:0]   wr_sel;
    logic [15:0]  bus_out;
    logic [7:0]   wr_en;
    logic         xfer_done;
    logic         err_sel;
    logic [15:0]  xfer_count;

    logic [15:0]  src_v [1:10];
    logic [15:0]  exp_count;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 1; k <= 10; k++) begin
            src_flat[(k-1)*16 +: 16] = src_v[k];
        end
    end

    bus_xfer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .src_flat   (src_flat),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .rd_sel     (rd_sel),
        .wr_sel     (wr_sel),
        .bus_out    (bus_out),
        .wr_en      (wr_en),
        .xfer_done  (xfer_done),
        .err_sel    (err_sel),
        .xfer_count (xfer_count)
    );

    // Runs one isolated transfer from a falling edge in IDLE and checks every cycle of it.
    task automatic do_xfer(input string tag, input logic [3:0] rd, input logic [3:0] wr,
                           input logic [15:0] exp_bus, input logic [7:0] exp_wr, input logic exp_err);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait got %b exp 1", tag, req_ready);
        end
        rd_sel = rd; wr_sel = wr; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (bus_out !== exp_bus) begin
            errors++; $display("FAIL %s bus_T1 got %h exp %h", tag, bus_out, exp_bus);
        end
        checks++;
        if (err_sel !== exp_err) begin
            errors++; $display("FAIL %s err_sel got %b exp %b", tag, err_sel, exp_err);
        end
        checks++;
        if (wr_en !== 8'h00 || req_ready !== 1'b0) begin
            errors++; $display("FAIL %s drive_cycle wr_en %h ready %b exp 00 0", tag, wr_en, req_ready);
        end
        @(negedge clk);
        checks++;
        if (wr_en !== exp_wr) begin
            errors++; $display("FAIL %s wr_en got %h exp %h", tag, wr_en, exp_wr);
        end
        checks++;
        if (bus_out !== exp_bus || err_sel !== 1'b0 || xfer_done !== 1'b0) begin
            errors++; $display("FAIL %s commit_cycle bus %h err %b done %b exp %h 0 0", tag, bus_out, err_sel, xfer_done, exp_bus);
        end
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        checks++;
        if (xfer_done !== 1'b1 || wr_en !== 8'h00 || req_ready !== 1'b1) begin
            errors++; $display("FAIL %s retire done %b wr_en %h ready %b exp 1 00 1", tag, xfer_done, wr_en, req_ready);
        end
        checks++;
        if (xfer_count !== exp_count) begin
            errors++; $display("FAIL %s xfer_count got %h exp %h", tag, xfer_count, exp_count);
        end
        @(negedge clk);
        checks++;
        if (xfer_done !== 1'b0 || bus_out !== exp_bus) begin
            errors++; $display("FAIL %s post done %b bus %h exp 0 %h", tag, xfer_done, bus_out, exp_bus);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rd_sel = 4'd0; wr_sel = 4'd0;
        for (int k = 1; k <= 10; k++) src_v[k] = 16'h1000 + 16'(k);
        exp_count = 16'd0;
        @(negedge clk);
        checks++;
        if (bus_out !== 16'h0 || wr_en !== 8'h0 || xfer_done !== 1'b0 || err_sel !== 1'b0) begin
            errors++; $display("FAIL reset outputs bus %h wr %h done %b err %b exp 0", bus_out, wr_en, xfer_done, err_sel);
        end
        checks++;
        if (xfer_count !== 16'h0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL reset count %h ready %b exp 0000 1", xfer_count, req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        src_v[4] = 16'hA5A5;
        do_xfer("basic", 4'd4, 4'd3, 16'hA5A5, 8'b0000_0100, 1'b0);
    endtask

    task automatic test_mux();
        src_v[9]  = 16'hBEEF;
        src_v[10] = 16'hC3D2;
        do_xfer("narrow", 4'd9, 4'd1, 16'h00EF, 8'h01, 1'b0);
        do_xfer("top_src", 4'd10, 4'd8, 16'hC3D2, 8'h80, 1'b0);
        do_xfer("zero_src", 4'd0, 4'd6, 16'h0000, 8'h20, 1'b0);
        do_xfer("bus_only", 4'd4, 4'd0, 16'hA5A5, 8'h00, 1'b0);
    endtask

    task automatic test_illegal();
        src_v[4] = 16'h7777;
        do_xfer("illegal_both", 4'd12, 4'd9, 16'h0000, 8'h00, 1'b1);
        do_xfer("illegal_wr", 4'd4, 4'd15, 16'h7777, 8'h00, 1'b1);
        do_xfer("illegal_rd", 4'd11, 4'd2, 16'h0000, 8'h02, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  rd_t  [4];
        logic [3:0]  wr_t  [4];
        logic [15:0] bus_t [4];
        logic [7:0]  we_t  [4];
        rd_t = '{4'd1, 4'd10, 4'd5, 4'd0};
        wr_t = '{4'd8, 4'd0, 4'd2, 4'd5};
        bus_t = '{16'h1111, 16'hAAAA, 16'h5555, 16'h0000};
        we_t = '{8'h80, 8'h00, 8'h02, 8'h10};
        src_v[1] = 16'h1111; src_v[10] = 16'hAAAA; src_v[5] = 16'h5555;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_sel = rd_t[i]; wr_sel = wr_t[i];
            checks++;
            if (req_ready !== 1'b1) begin
                errors++; $display("FAIL b2b[%0d] ready_at_accept got %b exp 1", i, req_ready);
            end
            @(negedge clk);
            checks++;
            if (bus_out !== bus_t[i] || req_ready !== 1'b0) begin
                errors++; $display("FAIL b2b[%0d] drive bus %h ready %b exp %h 0", i, bus_out, req_ready, bus_t[i]);
            end
            if (rd_t[i] != 4'd0) src_v[rd_t[i]] = ~src_v[rd_t[i]];
            rd_sel = 4'd3;
            @(negedge clk);
            checks++;
            if (wr_en !== we_t[i] || bus_out !== bus_t[i]) begin
                errors++; $display("FAIL b2b[%0d] commit wr_en %h bus %h exp %h %h", i, wr_en, bus_out, we_t[i], bus_t[i]);
            end
            @(negedge clk);
            exp_count = exp_count + 16'd1;
            checks++;
            if (xfer_done !== 1'b1 || xfer_count !== exp_count || req_ready !== 1'b1) begin
                errors++; $display("FAIL b2b[%0d] retire done %b count %h ready %b exp 1 %h 1", i, xfer_done, xfer_count, req_ready, exp_count);
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || xfer_done !== 1'b0 || wr_en !== 8'h00) begin
            errors++; $display("FAIL b2b_tail ready %b done %b wr_en %h exp 1 0 00", req_ready, xfer_done, wr_en);
        end
    endtask

    task automatic test_reset_mid();
        logic       seen_wr;
        logic       seen_done;
        src_v[4] = 16'hA5A5;
        rd_sel = 4'd4; wr_sel = 4'd3; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_out !== 16'h0 || err_sel !== 1'b0 || xfer_count !== 16'h0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid bus %h err %b count %h ready %b exp 0000 0 0000 1", bus_out, err_sel, xfer_count, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_count = 16'd0;
        seen_wr = 1'b0; seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wr_en !== 8'h00) seen_wr = 1'b1;
            if (xfer_done !== 1'b0) seen_done = 1'b1;
        end
        checks++;
        if (seen_wr !== 1'b0 || seen_done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after wr_seen %b done_seen %b exp 0 0", seen_wr, seen_done);
        end
        do_xfer("after_reset", 4'd4, 4'd3, 16'hA5A5, 8'b0000_0100, 1'b0);
    endtask

    task automatic test_wrap();
        force dut.count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.count_q;
        @(negedge clk);
        exp_count = 16'hFFFF;
        checks++;
        if (xfer_count !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_preload got %h exp ffff", xfer_count);
        end
        src_v[2] = 16'h1234;
        do_xfer("wrap", 4'd2, 4'd0, 16'h1234, 8'h00, 1'b0);
        checks++;
        if (xfer_count !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero got %h exp 0000", xfer_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mux();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
